// File: rtl/mash_pkg.sv
// Shared types and helpers for the MASH 1-1 / DWA output stage.
package mash_pkg;

    localparam int unsigned N_ELEM  = 3;
    localparam int unsigned LEVEL_W = 2;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [N_ELEM-1:0]  elem_t;
    typedef logic [1:0]         ptr_t;

    // Unary (thermometer) code: level n turns on the n lowest elements.
    function automatic elem_t therm(level_t lvl);
        elem_t t;
        case (lvl)
            2'd0:    t = 3'b000;
            2'd1:    t = 3'b001;
            2'd2:    t = 3'b011;
            default: t = 3'b111;
        endcase
        return t;
    endfunction

    // out[i] = t[(i - p) mod 3], i.e. rotate the code left by p positions.
    function automatic elem_t rotate(elem_t t, ptr_t p);
        elem_t r;
        case (p)
            2'd1:    r = {t[1:0], t[2]};
            2'd2:    r = {t[0], t[2:1]};
            default: r = t;
        endcase
        return r;
    endfunction

    // (p + lvl) mod 3 for p in 0..2 and lvl in 0..3.
    function automatic ptr_t ptr_advance(ptr_t p, level_t lvl);
        logic [2:0] sum;
        ptr_t       n;
        sum = {1'b0, p} + {1'b0, lvl};
        case (sum)
            3'd0, 3'd3: n = 2'd0;
            3'd1, 3'd4: n = 2'd1;
            default:    n = 2'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dwa_encoder.sv
// Data-weighted-averaging encoder: rotates the thermometer code of each level
// by a running pointer so that element usage is spread evenly.
module dwa_encoder
    import mash_pkg::*;
#(
    parameter bit DWA_EN = 1'b1
) (
    input  logic               aclk,
    input  logic               arst,
    input  logic [LEVEL_W-1:0] level,
    input  logic               lvl_valid,
    output logic [N_ELEM-1:0]  m_tdata,
    output logic               m_tvalid
);

    ptr_t  ptr_q,    ptr_d;
    elem_t tdata_q,  tdata_d;
    logic  tvalid_q, tvalid_d;

    // Next pointer and output word; idle cycles drive all elements off.
    always_comb begin
        ptr_d    = ptr_q;
        tdata_d  = '0;
        tvalid_d = 1'b0;
        if (lvl_valid) begin
            tdata_d  = rotate(therm(level), ptr_q);
            tvalid_d = 1'b1;
            if (DWA_EN) begin
                ptr_d = ptr_advance(ptr_q, level);
            end
        end
    end

    // Pointer and registered output.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            ptr_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;

endmodule

// File: rtl/axis_mash_dwa.sv
// MASH 1-1 noise cancellation (y = c1 + c2 - c2[n-1]) with a DWA-driven
// 3-element unary DAC output. Two input holds join the carry streams.
module axis_mash_dwa
    import mash_pkg::*;
#(
    parameter bit DWA_EN = 1'b1
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              s_axis_c1_tdata,
    input  logic              s_axis_c1_tvalid,
    output logic              s_axis_c1_tready,
    input  logic              s_axis_c2_tdata,
    input  logic              s_axis_c2_tvalid,
    output logic              s_axis_c2_tready,
    output logic [N_ELEM-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid
);

    logic h1_q, h1_d, h1_full_q, h1_full_d;
    logic h2_q, h2_d, h2_full_q, h2_full_d;
    logic fire, hs1, hs2;

    level_t level_q, level_d;
    logic   c2_z1_q, c2_z1_d;
    logic   lvl_valid_q, lvl_valid_d;

    logic signed [2:0] lvl_wide;

    assign fire = h1_full_q & h2_full_q;

    // A hold accepts when empty or when it is being drained this cycle.
    assign s_axis_c1_tready = (~h1_full_q | fire) & ~arst;
    assign s_axis_c2_tready = (~h2_full_q | fire) & ~arst;

    assign hs1 = s_axis_c1_tvalid & s_axis_c1_tready;
    assign hs2 = s_axis_c2_tvalid & s_axis_c2_tready;

    // Hold next-state: load on handshake, empty when consumed without refill.
    always_comb begin
        h1_d      = h1_q;
        h1_full_d = h1_full_q;
        h2_d      = h2_q;
        h2_full_d = h2_full_q;
        if (hs1) begin
            h1_d      = s_axis_c1_tdata;
            h1_full_d = 1'b1;
        end else if (fire) begin
            h1_full_d = 1'b0;
        end
        if (hs2) begin
            h2_d      = s_axis_c2_tdata;
            h2_full_d = 1'b1;
        end else if (fire) begin
            h2_full_d = 1'b0;
        end
    end

    // Input hold registers.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            h1_q      <= 1'b0;
            h1_full_q <= 1'b0;
            h2_q      <= 1'b0;
            h2_full_q <= 1'b0;
        end else begin
            h1_q      <= h1_d;
            h1_full_q <= h1_full_d;
            h2_q      <= h2_d;
            h2_full_q <= h2_full_d;
        end
    end

    // Noise-cancelled level, offset by one so the range is 0..3.
    always_comb begin
        lvl_wide = $signed({2'b00, h1_q}) + $signed({2'b00, h2_q})
                 - $signed({2'b00, c2_z1_q}) + 3'sd1;
        assert (lvl_wide >= 3'sd0);
        level_d     = level_q;
        c2_z1_d     = c2_z1_q;
        lvl_valid_d = 1'b0;
        if (fire) begin
            level_d     = level_t'(lvl_wide[1:0]);
            c2_z1_d     = h2_q;
            lvl_valid_d = 1'b1;
        end
    end

    // Stage-1 registers: level, stage-2 carry delay and level strobe.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            level_q     <= '0;
            c2_z1_q     <= 1'b0;
            lvl_valid_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            c2_z1_q     <= c2_z1_d;
            lvl_valid_q <= lvl_valid_d;
        end
    end

    dwa_encoder #(
        .DWA_EN (DWA_EN)
    ) u_dwa (
        .aclk      (aclk),
        .arst      (arst),
        .level     (level_q),
        .lvl_valid (lvl_valid_q),
        .m_tdata   (m_axis_data_tdata),
        .m_tvalid  (m_axis_data_tvalid)
    );

endmodule

// File: tb/tb_axis_mash_dwa.sv
// Scoreboard bench for axis_mash_dwa: accepted beats are paired by a
// behavioural model that predicts each output word and the cycle it appears.
module tb_axis_mash_dwa;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic       c1_d = 1'b0, c1_v = 1'b0, c1_r;
    logic       c2_d = 1'b0, c2_v = 1'b0, c2_r;
    logic [2:0] tdata;
    logic       tvalid;

    axis_mash_dwa #(.DWA_EN(1'b1)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_c1_tdata    (c1_d),
        .s_axis_c1_tvalid   (c1_v),
        .s_axis_c1_tready   (c1_r),
        .s_axis_c2_tdata    (c2_d),
        .s_axis_c2_tvalid   (c2_v),
        .s_axis_c2_tready   (c2_r),
        .m_axis_data_tdata  (tdata),
        .m_axis_data_tvalid (tvalid)
    );

    always #5 aclk = ~aclk;

    typedef struct { bit d; int edge_n; } beat_t;
    typedef struct { logic [2:0] data; int due; } exp_t;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    bit    src1[$], src2[$];
    int    gap1 = 0, gap2 = 0;
    beat_t q1[$], q2[$];
    exp_t  sb[$];
    logic [2:0] seen[$];
    int    m_ptr = 0;
    bit    m_c2prev = 1'b0;
    int    last_pair_k = -10;
    int    pairs = 0;
    bit    hs1_n = 1'b0, hs2_n = 1'b0;

    always @(posedge aclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: presents queued beats, holding each one until it is accepted.
    always @(posedge aclk) begin
        #1;
        if (hs1_n && src1.size() > 0) void'(src1.pop_front());
        if (hs2_n && src2.size() > 0) void'(src2.pop_front());
        if (arst || src1.size() == 0) c1_v = 1'b0;
        else begin
            if (!(c1_v && !hs1_n)) c1_v = ($urandom_range(99) >= gap1);
            c1_d = src1[0];
        end
        if (arst || src2.size() == 0) c2_v = 1'b0;
        else begin
            if (!(c2_v && !hs2_n)) c2_v = ($urandom_range(99) >= gap2);
            c2_d = src2[0];
        end
    end

    // Reference model: tracks accepted beats, pairs them in order and
    // predicts the DAC word from y = c1 + c2 - c2_prev and a mod-3 pointer.
    always @(negedge aclk) begin
        if (arst) begin
            chk("c1_tready_in_reset", c1_r, 0);
            chk("c2_tready_in_reset", c2_r, 0);
            q1.delete();
            q2.delete();
            m_ptr = 0;
            m_c2prev = 1'b0;
            last_pair_k = -10;
            hs1_n = 1'b0;
            hs2_n = 1'b0;
        end else begin
            chk("c1_tready", c1_r, (q1.size() == 0 || last_pair_k == cyc) ? 1 : 0);
            chk("c2_tready", c2_r, (q2.size() == 0 || last_pair_k == cyc) ? 1 : 0);
            hs1_n = c1_v && c1_r;
            hs2_n = c2_v && c2_r;
            if (hs1_n) q1.push_back('{c1_d, cyc + 1});
            if (hs2_n) q2.push_back('{c2_d, cyc + 1});
            while (q1.size() > 0 && q2.size() > 0) begin
                beat_t b1, b2;
                int lvl, k;
                logic [2:0] e;
                b1 = q1.pop_front();
                b2 = q2.pop_front();
                k = (b1.edge_n > b2.edge_n) ? b1.edge_n : b2.edge_n;
                lvl = int'(b1.d) + int'(b2.d) - int'(m_c2prev) + 1;
                m_c2prev = b2.d;
                e = '0;
                for (int i = 0; i < 3; i++)
                    if (((i - m_ptr + 3) % 3) < lvl) e[i] = 1'b1;
                m_ptr = (m_ptr + lvl) % 3;
                sb.push_back('{e, k + 2});
                last_pair_k = k;
                pairs++;
            end
        end
    end

    // Monitor: compares every presented output word with the scoreboard.
    always @(negedge aclk) begin
        if (arst) begin
            chk("tvalid_in_reset", tvalid, 0);
            chk("tdata_in_reset", tdata, 0);
            sb.delete();
        end else if (tvalid) begin
            seen.push_back(tdata);
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tdata", tdata, e.data);
                chk("latency_cycle", cyc, e.due);
            end
        end else begin
            chk("idle_tdata", tdata, 0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_beat", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge aclk);
        #2;
        arst = 1'b1;
        src1.delete();
        src2.delete();
        c1_v = 1'b0;
        c2_v = 1'b0;
        repeat (n) @(posedge aclk);
        #2;
        arst = 1'b0;
    endtask

    task automatic load1(input logic [63:0] a, input int n);
        logic [63:0] v;
        v = a;
        for (int i = 0; i < n; i++) src1.push_back(v[i]);
    endtask

    task automatic load2(input logic [63:0] b, input int n);
        logic [63:0] v;
        v = b;
        for (int i = 0; i < n; i++) src2.push_back(v[i]);
    endtask

    task automatic drain(input string name, input int bound);
        int k;
        k = 0;
        while ((src1.size() > 0 || src2.size() > 0 || q1.size() > 0 ||
                q2.size() > 0 || sb.size() > 0) && k < bound) begin
            @(posedge aclk);
            k++;
        end
        repeat (3) @(posedge aclk);
        chk({name, "_drain_timeout"}, (k < bound) ? 1 : 0, 1);
    endtask

    task automatic chk_seen(input string name, input int idx, input logic [2:0] exp);
        chk(name, (seen.size() > idx) ? 32'(seen[idx]) : 32'hFFFF, 32'(exp));
    endtask

    initial begin
        int start;
        gap1 = 0;
        gap2 = 0;
        // Reset held for three cycles, released away from the edge.
        repeat (3) @(posedge aclk);
        #2;
        arst = 1'b0;

        // Constant c1=1, c2=0: level 2, words cycle 011,101,110.
        seen.delete();
        load1(64'hFF, 8);
        load2(64'h00, 8);
        drain("const", 200);
        chk_seen("const_w0", 0, 3'b011);
        chk_seen("const_w1", 1, 3'b101);
        chk_seen("const_w2", 2, 3'b110);
        chk_seen("const_w3", 3, 3'b011);

        // Toggling c2 from a clean state: 011,000,101,000.
        do_reset(2);
        seen.delete();
        load1(64'h0, 4);
        load2(64'b0101, 4);
        drain("toggle", 200);
        chk_seen("toggle_w0", 0, 3'b011);
        chk_seen("toggle_w1", 1, 3'b000);
        chk_seen("toggle_w2", 2, 3'b101);
        chk_seen("toggle_w3", 3, 3'b000);

        // Extremes: (1,1) -> 111, then (0,0) -> 000.
        do_reset(2);
        seen.delete();
        load1(64'b01, 2);
        load2(64'b01, 2);
        drain("extreme", 200);
        chk_seen("extreme_w0", 0, 3'b111);
        chk_seen("extreme_w1", 1, 3'b000);
        chk("extreme_count", seen.size(), 2);

        // Skew: c1 offered three cycles before c2.
        seen.delete();
        load1(64'b1011, 4);
        repeat (3) @(posedge aclk);
        chk("skew_no_early_output", seen.size(), 0);
        load2(64'b0110, 4);
        drain("skew", 200);
        chk("skew_count", seen.size(), 4);

        // Reset mid-stream after five pairs, then a fresh (1,0) pair.
        load1(64'($urandom()), 10);
        load2(64'($urandom()), 10);
        start = pairs;
        for (int k = 0; k < 200 && pairs < start + 5; k++) @(posedge aclk);
        chk("midreset_reached_5_pairs", (pairs >= start + 5) ? 1 : 0, 1);
        do_reset(2);
        seen.delete();
        load1(64'b1, 1);
        load2(64'b0, 1);
        drain("midreset", 200);
        chk_seen("midreset_w0", 0, 3'b011);
        chk("midreset_count", seen.size(), 1);

        // Randomised traffic with independent stalls on each input.
        for (int b = 0; b < 6; b++) begin
            gap1 = $urandom_range(60);
            gap2 = $urandom_range(60);
            load1({$urandom(), $urandom()}, 60);
            load2({$urandom(), $urandom()}, 60);
            drain("random", 3000);
        end
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_mash_dwa.md
# axis_mash_dwa

MASH 1-1 noise-cancellation and unit-element output stage. It sits directly downstream of the two cascaded `axis_efm` first-order modulators. It consumes their 1-bit carry streams `c1` and `c2` and forms the 4-level MASH output `y = c1 + c2 - c2[n-1]`. It then drives a 3-element unary DAC through data-weighted averaging (DWA) so that element mismatch is first-order shaped.

## Interface

Parameters:
- `DWA_EN`, default 1: 1 = rotating DWA pointer; 0 = pointer held at 0 (plain thermometer).

Ports:
- `aclk`  in  1  system clock; all logic on the rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `s_axis_c1_tdata`  in  1  stage-1 EFM output bit.
- `s_axis_c1_tvalid`  in  1  stage-1 beat valid.
- `s_axis_c1_tready`  out  1  stage-1 accept.
- `s_axis_c2_tdata`  in  1  stage-2 EFM output bit.
- `s_axis_c2_tvalid`  in  1  stage-2 beat valid.
- `s_axis_c2_tready`  out  1  stage-2 accept.
- `m_axis_data_tdata`  out  3  unit-element drive, bit i = element i on.
- `m_axis_data_tvalid`  out  1  output beat valid; there is no tready (pins and analog elements are always ready).

## Operation

- **Input holding:** each input has a 1-entry hold register (`h1`/`h1_full`, `h2`/`h2_full`).
  - `fire = h1_full & h2_full`.
  - `s_axis_cX_tready = (!hX_full | fire) & !arst`.
  - A handshake loads `hX` and sets `hX_full`.
  - `fire` without a new handshake clears `hX_full`. `fire` together with a new handshake keeps `hX_full` set with the new data.
- **Join:** a pair is consumed only when both holds are full. A lone beat on one input waits indefinitely. Its tready stays low until the partner arrives.
- **Stage 1 (on `fire`):**
  - `level <= h1 + h2 - c2_z1 + 1`, unsigned 2 bits, range 0..3. No overflow is possible; compute internally at 3 bits signed.
  - `c2_z1 <= h2`.
  - `lvl_valid <= 1`; otherwise `lvl_valid <= 0`, and `level` and `c2_z1` hold.
- **Stage 2 (on `lvl_valid`):**
  - Thermometer code: 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111.
  - `out[i] = therm[(i - ptr) mod 3]`.
  - `ptr <= (ptr + level) mod 3` if `DWA_EN`; otherwise `ptr` stays 0.
  - `m_axis_data_tvalid <= 1`, `m_axis_data_tdata <= out`.
  - Otherwise `m_axis_data_tvalid <= 0` and `m_axis_data_tdata <= 000`, so idle elements are off.
- **Pointer:** `ptr` range 0..2. Level 3 leaves `ptr` unchanged; level 0 leaves the output at 000 and `ptr` unchanged.

## Timing

- **Reset values** (asynchronous on `arst`):
  - `m_axis_data_tdata = 000`, `m_axis_data_tvalid = 0`.
  - Both treadys 0 while `arst` is high; 1 in the first cycle after release.
  - Holds empty, `c2_z1 = 0`, `ptr = 0`, `lvl_valid = 0`.
- **Latency:** 2 cycles. The later of the two input handshakes at edge k gives `fire` at edge k+1, `level` registered at edge k+1, and `m_axis_data_tvalid` high after edge k+2.
- **Throughput:** 1 pair per cycle when both inputs are valid every cycle.
- **Reset mid-stream:** any in-flight pair is dropped, and `c2_z1` and `ptr` restart at 0. The first post-reset beat therefore uses `c2_z1 = 0`.

## Structure

- Package `mash_pkg`:
  - `N_ELEM = 3`, `LEVEL_W = 2`.
  - `typedef logic [LEVEL_W-1:0] level_t`, `typedef logic [N_ELEM-1:0] elem_t`, `typedef logic [1:0] ptr_t`.
  - Function `therm(level_t)`.
- Sub-module `dwa_encoder`: stage 2 (pointer register, rotate, output register). Inputs are `aclk`, `arst`, `level`, `lvl_valid`; parameter `DWA_EN`.
- Top `axis_mash_dwa`: holds, join, and stage 1.

## Test plan

1. **Reset:** hold `arst` for 3 cycles.
   - During reset: treadys 0, tdata 000, tvalid 0.
   - First cycle after release: treadys 1.
2. **Constant input:** `c1 = 1`, `c2 = 0`, both valid every cycle, `DWA_EN = 1`.
   - Level 2 on every beat.
   - tdata sequence 011, 101, 110, 011, ...
   - First tvalid 2 cycles after the first handshake, then continuous.
3. **Toggling stage 2:** `c1 = 0`, `c2` = 1, 0, 1, 0.
   - Levels 2, 0, 2, 0.
   - tdata 011, 000, 101, 000.
   - `ptr` goes 0 -> 2 -> 2 -> 1 -> 1.
4. **Extremes:** first pair (1, 1) gives level 3 and tdata 111 with `ptr` still 0. Next pair (0, 0) gives level 0 and tdata 000.
5. **Input skew:** `c1` is valid 3 cycles before `c2`.
   - `s_axis_c1_tready` drops after the first capture.
   - No output appears until `c2` is accepted; tvalid follows 2 cycles later.
   - No `c1` beat is lost or duplicated.
6. **Reset mid-stream:** assert `arst` after the 5th pair.
   - Output returns to 000/0 immediately.
   - After release, a (1, 0) pair yields level 2 and tdata 011, confirming `ptr` and `c2_z1` were cleared.
